apple_speaker_pcm: RTL and testbench

- Parametrised successor to the 1-bit Apple II speaker: N soft-switch toggle channels, each producing a signed PCM level with an idle timeout and a linear decay.
- Default channels: speaker $C030 and cassette-out $C020.
- Channels are summed into one saturated signed sample for the audio mixer. A legacy 1-bit speaker output is kept for the PWM path.
- Sits beside the other a2bus sound slaves; fed from the bus strobes on clk_logic.

---
 rtl/apple_sound_pkg.sv | 28 ++
 rtl/apple_speaker_pcm_toggle_channel.sv | 71 +++++++
 rtl/apple_speaker_pcm.sv | 87 ++++++++
 tb/tb_apple_speaker_pcm.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/apple_sound_pkg.sv
// Shared constants, types and helpers for the Apple II sound slaves.
package apple_sound_pkg;

    // Default soft-switch addresses of the two classic 1-bit outputs.
    localparam logic [15:0] A2_SPKR_ADDR = 16'hC030;
    localparam logic [15:0] A2_CASS_ADDR = 16'hC020;

    localparam int SAMPLE_W_DEF = 16;

    typedef logic signed [SAMPLE_W_DEF-1:0] sample_t;

    // Clamp a signed value into the range of a w-bit signed sample (w <= 31).
    // The result stays 32 bits wide; the caller truncates to w bits.
    function automatic logic signed [31:0] sat_signed(input logic signed [31:0] v,
                                                      input int                 w);
        logic signed [31:0] hi;
        logic signed [31:0] lo;
        hi = (32'sd1 <<< (w - 1)) - 32'sd1;
        lo = -(32'sd1 <<< (w - 1));
        if (v > hi) begin
            return hi;
        end else if (v < lo) begin
            return lo;
        end
        return v;
    endfunction

endpackage

// File: rtl/apple_speaker_pcm_toggle_channel.sv
// One soft-switch toggle channel: polarity bit, magnitude with idle timeout
// and linear decay, and the resulting signed level.
module toggle_channel
    import apple_sound_pkg::*;
#(
    parameter int                  SAMPLE_W   = 16,
    parameter int                  TIMEOUT_W  = 24,
    parameter logic [SAMPLE_W-1:0] AMP        = 16'h2000,
    parameter logic [SAMPLE_W-1:0] DECAY_STEP = 16'h0010,
    parameter logic [15:0]         ADDR       = A2_SPKR_ADDR
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       phi1_i,
    input  logic [15:0]                addr_i,
    input  logic                       m2sel_n_i,
    output logic signed [SAMPLE_W-1:0] lvl_o,
    output logic                       spk_nxt_o
);

    // Magnitude never needs the sign bit: AMP is below 2^(SAMPLE_W-1).
    localparam int               MAG_W  = SAMPLE_W - 1;
    localparam logic [MAG_W-1:0] AMP_M  = AMP[MAG_W-1:0];
    localparam logic [MAG_W-1:0] STEP_M = DECAY_STEP[MAG_W-1:0];

    logic                 hit;
    logic                 bit_q, bit_d;
    logic [MAG_W-1:0]     mag_q, mag_d;
    logic [TIMEOUT_W-1:0] tmo_q, tmo_d;

    assign hit = phi1_i & ~m2sel_n_i & (addr_i == ADDR);

    // Next state: a hit reloads everything; otherwise each phi1 tick first
    // runs the idle timeout down, then decays the magnitude towards zero.
    always_comb begin
        bit_d = bit_q;
        mag_d = mag_q;
        tmo_d = tmo_q;
        if (hit) begin
            bit_d = ~bit_q;
            mag_d = AMP_M;
            tmo_d = '1;
        end else if (phi1_i) begin
            if (tmo_q != '0) begin
                tmo_d = tmo_q - TIMEOUT_W'(1);
            end else if (mag_q > STEP_M) begin
                mag_d = mag_q - STEP_M;
            end else begin
                mag_d = '0;
            end
        end
    end

    // Channel state register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            bit_q <= 1'b0;
            mag_q <= '0;
            tmo_q <= '0;
        end else begin
            bit_q <= bit_d;
            mag_q <= mag_d;
            tmo_q <= tmo_d;
        end
    end

    assign lvl_o     = bit_q ? $signed({1'b0, mag_q}) : -$signed({1'b0, mag_q});
    // Legacy speaker level is taken from the state being loaded this cycle.
    assign spk_nxt_o = bit_d & (tmo_d != '0);

endmodule

// File: rtl/apple_speaker_pcm.sv
// Multi-channel PCM successor to the Apple II 1-bit speaker: N toggle
// channels mixed into one saturated signed sample, plus the legacy 1-bit level.
module apple_speaker_pcm
    import apple_sound_pkg::*;
#(
    parameter int                        NUM_CH     = 2,
    parameter logic [NUM_CH-1:0][15:0]   CH_ADDR    = {A2_CASS_ADDR, A2_SPKR_ADDR},
    parameter int                        SAMPLE_W   = 16,
    parameter logic [SAMPLE_W-1:0]       AMP        = 16'h2000,
    parameter int                        TIMEOUT_W  = 24,
    parameter logic [SAMPLE_W-1:0]       DECAY_STEP = 16'h0010
) (
    input  logic                       clk_logic,
    input  logic                       system_reset_n,
    input  logic                       phi1_posedge,
    input  logic [15:0]                addr,
    input  logic                       m2sel_n,
    input  logic                       enable,
    output logic signed [SAMPLE_W-1:0] audio_o,
    output logic                       audio_valid_o,
    output logic                       speaker_o
);

    // Headroom for summing NUM_CH full-scale levels without overflow.
    localparam int SUM_W = SAMPLE_W + $clog2(NUM_CH) + 1;

    logic signed [SAMPLE_W-1:0] lvl [NUM_CH];
    logic                       spk_nxt [NUM_CH];

    logic signed [SUM_W-1:0]    sum_d;
    logic signed [SAMPLE_W-1:0] sat_d;

    logic                       tick_q;
    logic signed [SAMPLE_W-1:0] audio_q;
    logic                       valid_q;
    logic                       spk_q;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        toggle_channel #(
            .SAMPLE_W  (SAMPLE_W),
            .TIMEOUT_W (TIMEOUT_W),
            .AMP       (AMP),
            .DECAY_STEP(DECAY_STEP),
            .ADDR      (CH_ADDR[g])
        ) u_ch (
            .clk_i    (clk_logic),
            .rst_ni   (system_reset_n),
            .phi1_i   (phi1_posedge),
            .addr_i   (addr),
            .m2sel_n_i(m2sel_n),
            .lvl_o    (lvl[g]),
            .spk_nxt_o(spk_nxt[g])
        );
    end

    // Mixer: widen and sum every channel level, then clamp to the sample range.
    always_comb begin
        sum_d = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            sum_d = sum_d + SUM_W'(lvl[i]);
        end
        sat_d = SAMPLE_W'(sat_signed(32'(sum_d), SAMPLE_W));
    end

    // Output stage: tick_q marks that channel state was just refreshed by a
    // phi1 tick, so the mixed sample is captured (and flagged valid) one cycle later.
    always_ff @(posedge clk_logic or negedge system_reset_n) begin
        if (!system_reset_n) begin
            tick_q  <= 1'b0;
            audio_q <= '0;
            valid_q <= 1'b0;
            spk_q   <= 1'b0;
        end else begin
            tick_q  <= phi1_posedge;
            valid_q <= tick_q;
            spk_q   <= spk_nxt[0] & enable;
            if (tick_q) begin
                audio_q <= enable ? sat_d : '0;
            end
        end
    end

    assign audio_o       = audio_q;
    assign audio_valid_o = valid_q;
    assign speaker_o     = spk_q;

endmodule

// File: tb/tb_apple_speaker_pcm.sv
// Self-checking bench for apple_speaker_pcm: a vector table, directed
// multi-cycle sequences and randomized traffic against a behavioural model.
module tb_apple_speaker_pcm;

    logic               clk;
    logic               rst_n;
    logic               phi1;
    logic [15:0]        addr;
    logic               m2sel_n;
    logic               enable;
    logic signed [15:0] aud_a, aud_b;
    logic               vld_a, vld_b;
    logic               spk_a, spk_b;

    int checks   = 0;
    int failures = 0;

    // DUT A: default amplitude, short timeout. DUT B: large amplitude for clamping.
    apple_speaker_pcm #(.TIMEOUT_W(4)) dut_a (
        .clk_logic(clk), .system_reset_n(rst_n), .phi1_posedge(phi1), .addr(addr),
        .m2sel_n(m2sel_n), .enable(enable),
        .audio_o(aud_a), .audio_valid_o(vld_a), .speaker_o(spk_a)
    );

    apple_speaker_pcm #(.AMP(16'h7000), .TIMEOUT_W(4)) dut_b (
        .clk_logic(clk), .system_reset_n(rst_n), .phi1_posedge(phi1), .addr(addr),
        .m2sel_n(m2sel_n), .enable(enable),
        .audio_o(aud_b), .audio_valid_o(vld_b), .speaker_o(spk_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- behavioural reference model ----------------
    localparam int TMAX = 15;          // all ones for TIMEOUT_W=4
    localparam int STEP = 16;
    int          amp_of [2] = '{32'h2000, 32'h7000};
    logic [15:0] ch_addr[2] = '{16'hC030, 16'hC020};
    int m_bit[2][2], m_mag[2][2], m_tmo[2][2];
    int m_aud[2], m_vld[2], m_spk[2];
    int m_tick;

    function automatic int sat16(input int v);
        if (v > 32767)  return 32767;
        if (v < -32768) return -32768;
        return v;
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 2; i++) begin
                m_bit[d][i] = 0; m_mag[d][i] = 0; m_tmo[d][i] = 0;
            end
            m_aud[d] = 0; m_vld[d] = 0; m_spk[d] = 0;
        end
        m_tick = 0;
    endtask

    // Advance the model by one clock edge using the inputs present at that edge.
    task automatic model_step();
        for (int d = 0; d < 2; d++) begin
            int s;
            s = 0;
            for (int i = 0; i < 2; i++) s += (m_bit[d][i] != 0) ? m_mag[d][i] : -m_mag[d][i];
            if (m_tick != 0) m_aud[d] = enable ? sat16(s) : 0;
            m_vld[d] = m_tick;
            for (int i = 0; i < 2; i++) begin
                if (phi1 && !m2sel_n && addr == ch_addr[i]) begin
                    m_bit[d][i] = 1 - m_bit[d][i];
                    m_mag[d][i] = amp_of[d];
                    m_tmo[d][i] = TMAX;
                end else if (phi1 && m_tmo[d][i] != 0) begin
                    m_tmo[d][i] = m_tmo[d][i] - 1;
                end else if (phi1) begin
                    m_mag[d][i] = (m_mag[d][i] > STEP) ? m_mag[d][i] - STEP : 0;
                end
            end
            m_spk[d] = (m_bit[d][0] != 0 && m_tmo[d][0] != 0 && enable) ? 1 : 0;
        end
        m_tick = phi1 ? 1 : 0;
    endtask

    // ---------------- helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drv(input logic p, input logic [15:0] a, input logic ms, input logic en);
        phi1 = p; addr = a; m2sel_n = ms; enable = en;
    endtask

    // One clock: update model at the edge, sample DUTs 1 ns later, compare.
    task automatic step();
        @(posedge clk);
        model_step();
        #1;
        chk("mdl_audio_a", {16'h0, aud_a}, m_aud[0] & 32'hFFFF);
        chk("mdl_valid_a", {31'h0, vld_a}, m_vld[0]);
        chk("mdl_spk_a",   {31'h0, spk_a}, m_spk[0]);
        chk("mdl_audio_b", {16'h0, aud_b}, m_aud[1] & 32'hFFFF);
        chk("mdl_valid_b", {31'h0, vld_b}, m_vld[1]);
        chk("mdl_spk_b",   {31'h0, spk_b}, m_spk[1]);
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) begin
            drv(1'b1, 16'h0000, 1'b0, 1'b1);
            step();
        end
    endtask

    // Asynchronous reset: outputs must clear without any clock edge.
    task automatic do_reset();
        drv(1'b0, 16'h0000, 1'b1, 1'b1);
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("rst_audio_a", {16'h0, aud_a}, 32'h0);
        chk("rst_valid_a", {31'h0, vld_a}, 32'h0);
        chk("rst_spk_a",   {31'h0, spk_a}, 32'h0);
        chk("rst_audio_b", {16'h0, aud_b}, 32'h0);
        chk("rst_valid_b", {31'h0, vld_b}, 32'h0);
        chk("rst_spk_b",   {31'h0, spk_b}, 32'h0);
        #2;
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic        p;
        logic [15:0] a;
        logic        ms;
        logic        en;
        logic [15:0] aud;
        logic        vld;
        logic        spk;
    } vec_t;

    vec_t tbl[19];

    initial begin
        rst_n = 1'b1;
        drv(1'b0, 16'h0000, 1'b1, 1'b1);

        // Expected DUT A outputs after each edge (audio, valid, speaker).
        tbl[0]  = '{1'b1, 16'hC030, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b1};
        tbl[1]  = '{1'b0, 16'h0000, 1'b0, 1'b1, 16'h2000, 1'b1, 1'b1};
        tbl[2]  = '{1'b0, 16'h0000, 1'b0, 1'b1, 16'h2000, 1'b0, 1'b1};
        tbl[3]  = '{1'b1, 16'h0000, 1'b0, 1'b1, 16'h2000, 1'b0, 1'b1};
        tbl[4]  = '{1'b0, 16'h0000, 1'b0, 1'b1, 16'h2000, 1'b1, 1'b1};
        tbl[5]  = '{1'b1, 16'hC030, 1'b1, 1'b1, 16'h2000, 1'b0, 1'b1};
        tbl[6]  = '{1'b1, 16'hC030, 1'b0, 1'b1, 16'h2000, 1'b1, 1'b0};
        tbl[7]  = '{1'b0, 16'h0000, 1'b0, 1'b1, 16'hE000, 1'b1, 1'b0};
        tbl[8]  = '{1'b1, 16'hC020, 1'b0, 1'b1, 16'hE000, 1'b0, 1'b0};
        tbl[9]  = '{1'b0, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0};
        tbl[10] = '{1'b1, 16'hC030, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b1};
        tbl[11] = '{1'b0, 16'h0000, 1'b0, 1'b1, 16'h4000, 1'b1, 1'b1};
        tbl[12] = '{1'b0, 16'h0000, 1'b0, 1'b0, 16'h4000, 1'b0, 1'b0};
        tbl[13] = '{1'b1, 16'h0000, 1'b0, 1'b0, 16'h4000, 1'b0, 1'b0};
        tbl[14] = '{1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
        tbl[15] = '{1'b1, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b1};
        tbl[16] = '{1'b0, 16'h0000, 1'b0, 1'b1, 16'h4000, 1'b1, 1'b1};
        tbl[17] = '{1'b0, 16'hC030, 1'b0, 1'b1, 16'h4000, 1'b0, 1'b1};
        tbl[18] = '{1'b0, 16'h0000, 1'b0, 1'b1, 16'h4000, 1'b0, 1'b1};

        do_reset();
        for (int v = 0; v < 19; v++) begin
            drv(tbl[v].p, tbl[v].a, tbl[v].ms, tbl[v].en);
            step();
            chk($sformatf("tbl%0d_audio", v), {16'h0, aud_a}, {16'h0, tbl[v].aud});
            chk($sformatf("tbl%0d_valid", v), {31'h0, vld_a}, {31'h0, tbl[v].vld});
            chk($sformatf("tbl%0d_spk", v),   {31'h0, spk_a}, {31'h0, tbl[v].spk});
        end

        // Timeout, then linear decay down to exactly zero with no underflow.
        do_reset();
        drv(1'b1, 16'hC030, 1'b0, 1'b1);
        step();
        ticks(14);
        chk("tmo_spk_still_on", {31'h0, spk_a}, 32'h1);
        ticks(1);
        chk("tmo_spk_off", {31'h0, spk_a}, 32'h0);
        ticks(2);
        chk("decay_1ff0", {16'h0, aud_a}, 32'h1FF0);
        ticks(1);
        chk("decay_1fe0", {16'h0, aud_a}, 32'h1FE0);
        ticks(509);
        chk("decay_0010", {16'h0, aud_a}, 32'h0010);
        ticks(1);
        chk("decay_zero", {16'h0, aud_a}, 32'h0000);
        ticks(3);
        chk("decay_stays_zero", {16'h0, aud_a}, 32'h0000);

        // Hit on a decay tick at mag=0010h: reload wins, polarity flips, no dip to 0.
        do_reset();
        drv(1'b1, 16'hC030, 1'b0, 1'b1);
        step();
        ticks(15 + 511);
        drv(1'b1, 16'hC030, 1'b0, 1'b1);
        step();
        chk("hitdecay_prev", {16'h0, aud_a}, 32'h0010);
        chk("hitdecay_spk",  {31'h0, spk_a}, 32'h0);
        drv(1'b0, 16'h0000, 1'b0, 1'b1);
        step();
        chk("hitdecay_reload", {16'h0, aud_a}, 32'hE000);

        // Reset while decaying.
        do_reset();
        drv(1'b1, 16'hC030, 1'b0, 1'b1);
        step();
        ticks(20);
        do_reset();

        // Two channels at AMP=7000h clamp both ways.
        drv(1'b1, 16'hC030, 1'b0, 1'b1);
        step();
        drv(1'b1, 16'hC020, 1'b0, 1'b1);
        step();
        drv(1'b0, 16'h0000, 1'b0, 1'b1);
        step();
        chk("sat_pos", {16'h0, aud_b}, 32'h7FFF);
        drv(1'b1, 16'hC030, 1'b0, 1'b1);
        step();
        drv(1'b1, 16'hC020, 1'b0, 1'b1);
        step();
        drv(1'b0, 16'h0000, 1'b0, 1'b1);
        step();
        chk("sat_neg", {16'h0, aud_b}, 32'h8000);

        // Randomized traffic against the model, with one reset in the middle.
        for (int c = 0; c < 4000; c++) begin
            logic [15:0] a;
            case ($urandom_range(0, 3))
                0:       a = 16'hC030;
                1:       a = 16'hC020;
                2:       a = 16'hC000;
                default: a = 16'($urandom);
            endcase
            drv(($urandom_range(0, 2) == 0), a, ($urandom_range(0, 3) == 0),
                ($urandom_range(0, 15) != 0));
            step();
            if (c == 2000) do_reset();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
